// File: rtl/nla_fp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nla_fp_pkg                                                         |
// | Shared binary32 field constants and divider state encoding.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package nla_fp_pkg;
  localparam int FP_WIDTH = 32;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } div_state_t;
endpackage
`default_nettype wire

// File: rtl/fp32_divide_iter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp32_divide_iter_if                                                |
// | Operand/result handshake bundle for the iterative FP32 divider.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fp32_divide_iter_if
  import nla_fp_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             div_by_zero;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Result, div_by_zero, overflow, underflow
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Result, div_by_zero, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fp32_div_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp32_div_unpack                                                    |
// | Operand classification, sign/exponent and mantissa pre-normalise.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp32_div_unpack
  import nla_fp_pkg::*;
(
  input  logic               [31:0]     a,
  input  logic               [31:0]     b,
  output logic                          special,
  output logic               [31:0]     special_result,
  output logic                          special_dbz,
  output logic                          sign,
  output logic signed        [9:0]      exp_diff,
  output logic               [MANT_W:0] mant_b,
  output logic               [MANT_W+1:0] dividend
);
  logic              a_zero;
  logic              b_zero;
  logic              pre_shift;
  logic [MANT_W:0]   mant_a;

  always_comb begin
    a_zero    = (a[30:23] == '0);
    b_zero    = (b[30:23] == '0);
    sign      = a[31] ^ b[31];
    mant_a    = {1'b1, a[MANT_W-1:0]};
    mant_b    = {1'b1, b[MANT_W-1:0]};
    // Doubling a smaller dividend keeps the quotient in [1,2)
    pre_shift = (mant_a < mant_b);
    dividend  = pre_shift ? {mant_a, 1'b0} : {1'b0, mant_a};
    exp_diff  = 10'(a[30:23]) - 10'(b[30:23]) + 10'(EXP_BIAS) - {9'd0, pre_shift};

    special        = a_zero | b_zero;
    special_dbz    = b_zero;
    special_result = '0;
    if (a_zero && b_zero)
      special_result = QNAN_32;
    else if (b_zero)
      special_result = {sign, 8'hFF, 23'b0};
  end
endmodule
`default_nettype wire

// File: rtl/fp32_divide_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp32_divide_iter                                                   |
// | Radix-2 restoring FP32 divider, one quotient bit per clock.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp32_divide_iter
  import nla_fp_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QBITS = 24
)(
  input  logic               clk,
  input  logic               rst,
  fp32_divide_iter_if.slave  bus
);
  localparam int                      CNT_W    = $clog2(QBITS);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(QBITS - 1);
  localparam logic signed [9:0]       EXP_TOP  = 10'(EXP_MAX);

  div_state_t                r_state;
  div_state_t                w_next;
  logic [CNT_W-1:0]          r_count;
  logic [MANT_W+1:0]         r_rem;
  logic [MANT_W:0]           r_mb;
  logic [MANT_W-1:0]         r_q;
  logic                      r_sign;
  logic signed [9:0]         r_exp;
  logic [WIDTH-1:0]          r_result;
  logic                      r_dbz;
  logic                      r_ovf;
  logic                      r_unf;

  logic                      w_special;
  logic [31:0]               w_special_result;
  logic                      w_special_dbz;
  logic                      w_sign;
  logic signed [9:0]         w_exp_diff;
  logic [MANT_W:0]           w_mant_b;
  logic [MANT_W+1:0]         w_dividend;

  logic                      w_ge;
  logic [MANT_W:0]           w_diff;
  logic [MANT_W+1:0]         w_rem_next;
  logic [WIDTH-1:0]          w_pack_result;
  logic                      w_pack_ovf;
  logic                      w_pack_unf;

  fp32_div_unpack u_unpack (
    .a              (bus.A),
    .b              (bus.B),
    .special        (w_special),
    .special_result (w_special_result),
    .special_dbz    (w_special_dbz),
    .sign           (w_sign),
    .exp_diff       (w_exp_diff),
    .mant_b         (w_mant_b),
    .dividend       (w_dividend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = w_special ? DONE : DIVIDE;
      DIVIDE:  if (r_count == '0) w_next = NORM;
      NORM:    w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ge       = (r_rem >= {1'b0, r_mb});
    w_diff     = (MANT_W+1)'(r_rem - {1'b0, r_mb});
    w_rem_next = w_ge ? {w_diff, 1'b0} : {r_rem[MANT_W:0], 1'b0};

    w_pack_ovf    = 1'b0;
    w_pack_unf    = 1'b0;
    w_pack_result = {r_sign, r_exp[EXP_W-1:0], r_q};
    if (r_exp <= 10'sd0) begin
      w_pack_unf    = 1'b1;
      w_pack_result = {r_sign, 31'b0};
    end else if (r_exp >= EXP_TOP) begin
      w_pack_ovf    = 1'b1;
      w_pack_result = {r_sign, 8'hFF, 23'b0};
    end
  end

  // The leading integer bit is always 1 and falls off the top of r_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_mb     <= '0;
      r_q      <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_count  <= CNT_LAST;
          r_rem    <= w_dividend;
          r_mb     <= w_mant_b;
          r_q      <= '0;
          r_sign   <= w_sign;
          r_exp    <= w_exp_diff;
          r_result <= w_special ? w_special_result : '0;
          r_dbz    <= w_special_dbz;
          r_ovf    <= 1'b0;
          r_unf    <= 1'b0;
        end
        DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[MANT_W-2:0], w_ge};
          if (r_count != '0) r_count <= r_count - 1'b1;
        end
        NORM: begin
          r_result <= w_pack_result;
          r_ovf    <= w_pack_ovf;
          r_unf    <= w_pack_unf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.Result      = r_result;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_fp32_divide_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fp32_divide_iter                                                |
// | Directed self-checking bench for the iterative FP32 divider.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fp32_divide_iter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp32_divide_iter_if bus ();

  fp32_divide_iter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure latency to out_valid, optionally stall in DONE, then drain
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic dbz, input logic ovf,
                        input logic unf, input int lat, input int hold);
    int n;
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin
        bus.in_valid = 1'b0;
        bus.A        = 32'h0;
        bus.B        = 32'h0;
      end
      n++;
    end while (!bus.out_valid && n < 100);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_result"}, bus.Result, res);
    check({tag, "_flags"}, {29'd0, bus.div_by_zero, bus.overflow, bus.underflow},
          {29'd0, dbz, ovf, unf});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.A        = 32'h4000_0000;
        bus.B        = 32'h3F80_0000;
        @(negedge clk);
        check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, bus.Result, res);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  initial begin
    int  n;
    logic seen_valid;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = 32'h0;
    bus.B         = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.Result, 32'h0);
    check("rst_flags", {29'd0, bus.div_by_zero, bus.overflow, bus.underflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("six_by_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 26, 0);
    run_op("one_by_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 0, 0, 0, 26, 10);
    run_op("neg8_by_half", 32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 0, 0, 0, 26, 0);
    run_op("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0, 0, 1, 0);
    run_op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0, 0, 1, 0);
    run_op("zero_by_two", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 0, 1, 0);
    run_op("underflow",   32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 0, 0, 1, 26, 0);
    run_op("overflow",    32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 0, 1, 0, 26, 0);

    // Reset in the middle of a divide must discard it
    @(negedge clk);
    bus.A        = 32'h40C0_0000;
    bus.B        = 32'h4000_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_busy", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("mid_no_output", 32'(seen_valid), 32'd0);

    run_op("six_by_two_again", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 26, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
